// File: rtl/ctrl_pipe.sv
// Purpose: pipeline control for a 5-stage core; holds EX/MEM/WB control state, detects load-use hazards, squashes on redirect and selects EX operand forwarding.
// Latency: ID->EX, EX->MEM and MEM->WB are 1 cycle each; stall, flush_ifid and fwd_a/fwd_b are combinational.
// Backpressure: only stall holds PC and IF/ID (one bubble per load-use); stages below EX advance every cycle.
module ctrl_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_branch,
  input  logic       id_mr,
  input  logic       id_mwrite,
  input  logic       id_alusrc,
  input  logic       id_regwr,
  input  logic       id_jal,
  input  logic       id_jalr,
  input  logic [1:0] id_aluop,
  input  logic [1:0] id_mtoreg,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       redirect,
  output logic       stall,
  output logic       flush_ifid,
  output logic       ex_valid,
  output logic       ex_branch,
  output logic       ex_mr,
  output logic       ex_mwrite,
  output logic       ex_alusrc,
  output logic       ex_regwr,
  output logic       ex_jal,
  output logic       ex_jalr,
  output logic [1:0] ex_aluop,
  output logic [1:0] ex_mtoreg,
  output logic [4:0] ex_rs1,
  output logic [4:0] ex_rs2,
  output logic [4:0] ex_rd,
  output logic       mem_valid,
  output logic       mem_mr,
  output logic       mem_mwrite,
  output logic       mem_regwr,
  output logic [1:0] mem_mtoreg,
  output logic [4:0] mem_rd,
  output logic       wb_valid,
  output logic       wb_regwr,
  output logic [1:0] wb_mtoreg,
  output logic [4:0] wb_rd,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic load_use;
  logic bubble_in;
  logic mem_wr;
  logic wb_wr;

  // Hazard detection: a load in EX feeding the ID instruction costs one bubble; a redirect kills ID anyway so it wins.
  always_comb begin
    load_use   = id_valid && ex_valid && ex_mr && (ex_rd != 5'd0) &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    stall      = load_use && !redirect;
    flush_ifid = redirect;
    bubble_in  = redirect || stall || !id_valid;
  end

  // Forwarding select: the youngest producer (MEM) beats WB; x0 is never forwarded.
  always_comb begin
    mem_wr = mem_valid && mem_regwr && (mem_rd != 5'd0);
    wb_wr  = wb_valid && wb_regwr && (wb_rd != 5'd0);
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
    if (mem_wr && (mem_rd == ex_rs1)) begin
      fwd_a = 2'b10;
    end else if (wb_wr && (wb_rd == ex_rs1)) begin
      fwd_a = 2'b01;
    end
    if (mem_wr && (mem_rd == ex_rs2)) begin
      fwd_b = 2'b10;
    end else if (wb_wr && (wb_rd == ex_rs2)) begin
      fwd_b = 2'b01;
    end
  end

  // EX stage: capture the decoded instruction, or an all-zero bubble on stall, redirect or an invalid ID slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_branch <= 1'b0;
      ex_mr     <= 1'b0;
      ex_mwrite <= 1'b0;
      ex_alusrc <= 1'b0;
      ex_regwr  <= 1'b0;
      ex_jal    <= 1'b0;
      ex_jalr   <= 1'b0;
      ex_aluop  <= 2'b00;
      ex_mtoreg <= 2'b00;
      ex_rs1    <= 5'd0;
      ex_rs2    <= 5'd0;
      ex_rd     <= 5'd0;
    end else if (bubble_in) begin
      ex_valid  <= 1'b0;
      ex_branch <= 1'b0;
      ex_mr     <= 1'b0;
      ex_mwrite <= 1'b0;
      ex_alusrc <= 1'b0;
      ex_regwr  <= 1'b0;
      ex_jal    <= 1'b0;
      ex_jalr   <= 1'b0;
      ex_aluop  <= 2'b00;
      ex_mtoreg <= 2'b00;
      ex_rs1    <= 5'd0;
      ex_rs2    <= 5'd0;
      ex_rd     <= 5'd0;
    end else begin
      ex_valid  <= 1'b1;
      ex_branch <= id_branch;
      ex_mr     <= id_mr;
      ex_mwrite <= id_mwrite;
      ex_alusrc <= id_alusrc;
      // x0 is hardwired, so a write to it is dropped here once rather than checked downstream.
      ex_regwr  <= id_regwr && (id_rd != 5'd0);
      ex_jal    <= id_jal;
      ex_jalr   <= id_jalr;
      ex_aluop  <= id_aluop;
      ex_mtoreg <= id_mtoreg;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
    end
  end

  // MEM stage: unconditional advance of the fields memory and writeback still need.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      mem_mr     <= 1'b0;
      mem_mwrite <= 1'b0;
      mem_regwr  <= 1'b0;
      mem_mtoreg <= 2'b00;
      mem_rd     <= 5'd0;
    end else begin
      mem_valid  <= ex_valid;
      mem_mr     <= ex_mr;
      mem_mwrite <= ex_mwrite;
      mem_regwr  <= ex_regwr;
      mem_mtoreg <= ex_mtoreg;
      mem_rd     <= ex_rd;
    end
  end

  // WB stage: unconditional advance of the writeback fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_regwr  <= 1'b0;
      wb_mtoreg <= 2'b00;
      wb_rd     <= 5'd0;
    end else begin
      wb_valid  <= mem_valid;
      wb_regwr  <= mem_regwr;
      wb_mtoreg <= mem_mtoreg;
      wb_rd     <= mem_rd;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed hazard scenarios with literal expectations, then random instruction streams
// checked every cycle against an instruction-history model (last three issued instructions).
module tb_ctrl_pipe;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       mr;
    logic       mwrite;
    logic       alusrc;
    logic       regwr;
    logic       jal;
    logic       jalr;
    logic [1:0] aluop;
    logic [1:0] mtoreg;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   redirect = 1'b0;
  instr_t id = '0;

  logic       stall, flush_ifid;
  logic       ex_valid, ex_branch, ex_mr, ex_mwrite, ex_alusrc, ex_regwr, ex_jal, ex_jalr;
  logic [1:0] ex_aluop, ex_mtoreg;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic       mem_valid, mem_mr, mem_mwrite, mem_regwr;
  logic [1:0] mem_mtoreg;
  logic [4:0] mem_rd;
  logic       wb_valid, wb_regwr;
  logic [1:0] wb_mtoreg;
  logic [4:0] wb_rd;
  logic [1:0] fwd_a, fwd_b;

  int n_checks = 0;
  int n_fails  = 0;
  bit cmp_en   = 1'b0;

  // Model: hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB (bubbles are all-zero).
  instr_t hist [3] = '{default: '0};

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .rst(rst),
    .id_valid(id.valid), .id_branch(id.branch), .id_mr(id.mr), .id_mwrite(id.mwrite),
    .id_alusrc(id.alusrc), .id_regwr(id.regwr), .id_jal(id.jal), .id_jalr(id.jalr),
    .id_aluop(id.aluop), .id_mtoreg(id.mtoreg),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .redirect(redirect),
    .stall(stall), .flush_ifid(flush_ifid),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_mr(ex_mr), .ex_mwrite(ex_mwrite),
    .ex_alusrc(ex_alusrc), .ex_regwr(ex_regwr), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_aluop(ex_aluop), .ex_mtoreg(ex_mtoreg),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_mr(mem_mr), .mem_mwrite(mem_mwrite), .mem_regwr(mem_regwr),
    .mem_mtoreg(mem_mtoreg), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_mtoreg(wb_mtoreg), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Does instruction p deliver a usable result for register r?
  function automatic bit produces(input instr_t p, input logic [4:0] r);
    return p.valid && p.regwr && (p.rd != 5'd0) && (p.rd == r);
  endfunction

  function automatic bit exp_stall();
    bit uses;
    uses = (hist[0].rd == id.rs1) || (hist[0].rd == id.rs2);
    return id.valid && hist[0].valid && hist[0].mr && (hist[0].rd != 5'd0) && uses && !redirect;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (produces(hist[1], r)) return 2'b10;
    if (produces(hist[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  // What enters EX at the next edge: the ID instruction, unless it is killed or held.
  function automatic instr_t next_ex();
    instr_t n;
    if (!id.valid || redirect || exp_stall()) return '0;
    n = id;
    n.regwr = id.regwr && (id.rd != 5'd0);
    return n;
  endfunction

  // Model update: history shifts by one instruction per clock; reset empties it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist[0] <= '0;
      hist[1] <= '0;
      hist[2] <= '0;
    end else begin
      hist[0] <= next_ex();
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
  end

  // Compare process: every falling edge, all DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ex_bundle", 32'({ex_valid, ex_branch, ex_mr, ex_mwrite, ex_alusrc, ex_regwr, ex_jal, ex_jalr,
                              ex_aluop, ex_mtoreg, ex_rs1, ex_rs2, ex_rd}), 32'(hist[0]));
      check("mem_bundle", 32'({mem_valid, mem_mr, mem_mwrite, mem_regwr, mem_mtoreg, mem_rd}),
            32'({hist[1].valid, hist[1].mr, hist[1].mwrite, hist[1].regwr, hist[1].mtoreg, hist[1].rd}));
      check("wb_bundle", 32'({wb_valid, wb_regwr, wb_mtoreg, wb_rd}),
            32'({hist[2].valid, hist[2].regwr, hist[2].mtoreg, hist[2].rd}));
      check("stall", 32'(stall), 32'(exp_stall()));
      check("flush_ifid", 32'(flush_ifid), 32'(redirect));
      check("fwd_a", 32'(fwd_a), 32'(exp_fwd(hist[0].rs1)));
      check("fwd_b", 32'(fwd_b), 32'(exp_fwd(hist[0].rs2)));
      if (mem_valid && mem_mr) begin
        check("no_mem_load_fwd_a", 32'(fwd_a == 2'b10), 32'd0);
        check("no_mem_load_fwd_b", 32'(fwd_b == 2'b10), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic mr, input logic regwr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    id        = '0;
    id.valid  = 1'b1;
    id.mr     = mr;
    id.regwr  = regwr;
    id.mtoreg = mr ? 2'b01 : 2'b00;
    id.rd     = rd;
    id.rs1    = rs1;
    id.rs2    = rs2;
  endtask

  task automatic drain();
    id = '0;
    redirect = 1'b0;
    repeat (3) step();
  endtask

  task automatic rand_id();
    id        = instr_t'($urandom);
    id.valid  = ($urandom_range(0, 7) != 0);
    id.mr     = ($urandom_range(0, 2) == 0);
    id.rs1    = 5'($urandom_range(0, 7));
    id.rs2    = 5'($urandom_range(0, 7));
    id.rd     = 5'($urandom_range(0, 7));
  endtask

  initial begin
    bit hold;
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;
    step();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'd0);
    check("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    step();
    rst = 1'b0;

    // Back-to-back dependency: producer in MEM when consumer is in EX.
    set_id(1'b0, 1'b1, 5'd3, 5'd1, 5'd2); step();
    set_id(1'b0, 1'b1, 5'd8, 5'd3, 5'd4); step();
    @(negedge clk);
    check("rtype_fwd_mem", 32'(fwd_a), 32'd2);
    step(); drain();

    // One unrelated instruction in between: producer is in WB.
    set_id(1'b0, 1'b1, 5'd3, 5'd1, 5'd2); step();
    set_id(1'b0, 1'b1, 5'd9, 5'd10, 5'd11); step();
    set_id(1'b0, 1'b1, 5'd8, 5'd3, 5'd4); step();
    @(negedge clk);
    check("rtype_fwd_wb", 32'(fwd_a), 32'd1);
    step(); drain();

    // Load-use: one stall, one bubble, then the consumer takes the loaded value from WB.
    set_id(1'b1, 1'b1, 5'd5, 5'd1, 5'd0); step();
    set_id(1'b0, 1'b1, 5'd6, 5'd2, 5'd5);
    @(negedge clk);
    check("lu_stall", 32'(stall), 32'd1);
    step();
    @(negedge clk);
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_stall_drop", 32'(stall), 32'd0);
    step();
    @(negedge clk);
    check("lu_consumer_ex", 32'({ex_valid, ex_rd}), 32'({1'b1, 5'd6}));
    check("lu_fwd_b_wb", 32'(fwd_b), 32'd1);
    step(); drain();

    // Redirect beats load-use: no stall, IF/ID flushed, EX bubbled.
    set_id(1'b1, 1'b1, 5'd5, 5'd1, 5'd0); step();
    set_id(1'b0, 1'b1, 5'd6, 5'd5, 5'd2);
    redirect = 1'b1;
    @(negedge clk);
    check("redir_stall", 32'(stall), 32'd0);
    check("redir_flush", 32'(flush_ifid), 32'd1);
    step();
    check("redir_bubble", 32'(ex_valid), 32'd0);
    redirect = 1'b0;
    drain();

    // Writes to x0 are dropped and never forwarded.
    set_id(1'b0, 1'b1, 5'd0, 5'd0, 5'd0); step();
    check("x0_ex_regwr", 32'({ex_valid, ex_regwr}), 32'b10);
    set_id(1'b0, 1'b1, 5'd4, 5'd0, 5'd0); step();
    @(negedge clk);
    check("x0_mem_regwr", 32'({mem_valid, mem_regwr}), 32'b10);
    check("x0_no_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    id = '0; step();
    check("x0_wb_regwr", 32'({wb_valid, wb_regwr}), 32'b10);
    drain();

    // Both MEM and WB write x7: MEM wins.
    set_id(1'b0, 1'b1, 5'd7, 5'd1, 5'd2); step();
    set_id(1'b0, 1'b1, 5'd7, 5'd1, 5'd2); step();
    set_id(1'b0, 1'b0, 5'd9, 5'd7, 5'd3); step();
    @(negedge clk);
    check("mem_over_wb", 32'(fwd_a), 32'd2);
    step(); drain();

    // Reset in the middle of a load-use stall.
    set_id(1'b1, 1'b1, 5'd5, 5'd1, 5'd0); step();
    set_id(1'b0, 1'b1, 5'd6, 5'd5, 5'd2);
    @(negedge clk);
    check("rst_mid_stall_pre", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'd0);
    check("rst_mid_outs", 32'({flush_ifid, fwd_a, fwd_b}), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("post_rst_idle", 32'({ex_valid, ex_rd}), 32'd0);
    step();
    check("post_rst_capture", 32'({ex_valid, ex_rs1, ex_rd}), 32'({1'b1, 5'd5, 5'd6}));
    drain();

    // Random streams; a stalled ID instruction is re-presented unchanged.
    for (int i = 0; i < 3000; i++) begin
      hold = exp_stall();
      step();
      rst = ($urandom_range(0, 299) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      if (!hold) rand_id();
      @(negedge clk);
    end
    rst = 1'b0;
    redirect = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: id_valid  in  1  decode-stage instruction is real (not a bubble).
REQ-004 SHALL have ports: id_branch, id_mr, id_mwrite, id_alusrc, id_regwr, id_jal, id_jalr  in  1 each  decoded control bits.
REQ-005 SHALL have ports: id_aluop  in  2  ALU op class; id_mtoreg  in  2  writeback select.
REQ-006 SHALL have ports: id_rs1, id_rs2, id_rd  in  5 each  decode-stage register indices.
REQ-007 SHALL have ports: redirect  in  1  EX-stage taken branch/jal/jalr; younger instructions are wrong-path.
REQ-008 SHALL have ports: stall  out  1  hold PC and IF/ID register; flush_ifid  out  1  squash IF/ID register.
REQ-009 SHALL have ports: ex_valid, ex_branch, ex_mr, ex_mwrite, ex_alusrc, ex_regwr, ex_jal, ex_jalr  out  1 each; ex_aluop, ex_mtoreg  out  2; ex_rs1, ex_rs2, ex_rd  out  5.
REQ-010 SHALL have ports: mem_valid, mem_mr, mem_mwrite, mem_regwr  out  1; mem_mtoreg  out  2; mem_rd  out  5.
REQ-011 SHALL have ports: wb_valid, wb_regwr  out  1; wb_mtoreg  out  2; wb_rd  out  5.
REQ-012 SHALL have ports: fwd_a, fwd_b  out  2  EX operand source: 00 regfile, 01 WB result, 10 MEM result; 11 never driven.

Function
REQ-013 SHALL hold three registered stages EX, MEM, WB; each advances every cycle (no back-pressure below EX).
REQ-014 SHALL capture EX from ID fields each cycle unless a bubble is inserted; latency ID->EX 1 cycle, EX->MEM 1, MEM->WB 1.
REQ-015 SHALL define a bubble as valid=0 and every control bit/field 0 (mtoreg=00, aluop=00, indices 0).
REQ-016 SHALL assert stall combinationally when id_valid & ex_valid & ex_mr & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & !redirect (load-use).
REQ-017 SHALL insert a bubble into EX on the edge where stall=1; the ID instruction is re-presented next cycle and then captured.
REQ-018 SHALL drive flush_ifid = redirect and insert a bubble into EX on the edge where redirect=1; redirect takes priority over stall.
REQ-019 SHALL force captured ex_regwr to 0 when id_rd==0; x0 is never a write target downstream.
REQ-020 SHALL treat id_valid=0 as a bubble regardless of other ID inputs.
REQ-021 SHALL pass EX->MEM the fields valid, mr, mwrite, regwr, mtoreg, rd; MEM->WB the fields valid, regwr, mtoreg, rd, unchanged.
REQ-022 SHALL compute fwd_a: 10 if mem_valid & mem_regwr & mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_valid & wb_regwr & wb_rd!=0 & wb_rd==ex_rs1; else 00. fwd_b identically with ex_rs2.
REQ-023 SHALL give MEM priority over WB when both match (youngest producer wins).
REQ-024 SHALL never yield fwd=10 for a load in MEM; REQ-016 guarantees this, and verification SHALL assert it.
REQ-025 SHALL drive stall, flush_ifid, fwd_a, fwd_b combinationally from current stage registers and ID inputs; no other outputs are combinational.

Reset
REQ-026 SHALL, on rst=1 at any time (including mid-stall), asynchronously clear EX, MEM, WB to bubbles; stall=0, flush_ifid=0, fwd_a=fwd_b=00 while rst=1 with redirect=0.
REQ-027 SHALL resume capture on the first rising edge after rst deasserts.

Verification
REQ-028 R-type x3 then R-type reading x3: id(regwr=1,rd=3) cycle0, id(rs1=3) cycle1 -> cycle2 fwd_a=10; with one unrelated instr between -> fwd_a=01.
REQ-029 Load x5 then add rs2=5: -> stall=1 one cycle, EX bubble (ex_valid=0), add in EX cycle after, fwd_b=01 (load now in WB).
REQ-030 Load x5 in EX, ID rs1=5, redirect=1 same cycle -> stall=0, flush_ifid=1, EX bubble.
REQ-031 id_rd=0, id_regwr=1 -> ex_regwr=0, mem/wb regwr=0, no forwarding matches on rs=0.
REQ-032 Both MEM and WB write x7, ex_rs1=7 -> fwd_a=10.
REQ-033 Assert rst during load-use stall -> all stages bubble immediately, stall=0, outputs zero until first post-reset capture.
